// File: rtl/thresh_presets_stepper_pkg.sv
// Shared types and helpers for the preset stepper: FSM state encoding, table slicing, wrap arithmetic.
// Pure package; no logic or timing of its own.
package thresh_presets_pkg;

    localparam int PKG_TBL_W = 4096;
    localparam int PKG_MAX_W = 64;
    localparam int PKG_IDX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2
    } t_btn_rpt_state;

    // Entry k of an n-entry table sits MSB-first: entry 0 occupies the top w bits.
    function automatic logic [PKG_MAX_W-1:0] f_preset_slice(
        input logic [PKG_TBL_W-1:0] tbl,
        input int                   n,
        input int                   w,
        input int                   k
    );
        return PKG_MAX_W'(tbl >> ((n - 1 - k) * w));
    endfunction

    function automatic logic [PKG_IDX_W-1:0] f_wrap_inc(
        input logic [PKG_IDX_W-1:0] idx,
        input logic [PKG_IDX_W-1:0] count
    );
        return (idx >= count - 1'b1) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [PKG_IDX_W-1:0] f_wrap_dec(
        input logic [PKG_IDX_W-1:0] idx,
        input logic [PKG_IDX_W-1:0] count
    );
        return (idx == '0) ? count - 1'b1 : idx - 1'b1;
    endfunction

endpackage

// File: rtl/thresh_presets_stepper_if.sv
// Button, direct-load and preset-output signals of the stepper, bundled for the host side and the block.
// The master modport drives buttons/load requests; the slave (the stepper) drives the preset outputs.
interface thresh_presets_stepper_if #(
    parameter int IW = 4,
    parameter int W  = 16
);
    logic          i_btn_next;
    logic          i_btn_prev;
    logic          i_sel_valid;
    logic [IW-1:0] i_sel_index;
    logic [IW-1:0] o_value_enum;
    logic [W-1:0]  o_value_thresh;
    logic [W-1:0]  o_value_timer;
    logic          o_value_changed;
    logic          o_sel_error;

    modport master (
        output i_btn_next, i_btn_prev, i_sel_valid, i_sel_index,
        input  o_value_enum, o_value_thresh, o_value_timer, o_value_changed, o_sel_error
    );

    modport slave (
        input  i_btn_next, i_btn_prev, i_sel_valid, i_sel_index,
        output o_value_enum, o_value_thresh, o_value_timer, o_value_changed, o_sel_error
    );
endinterface

// File: rtl/thresh_presets_stepper_repeater.sv
// Button edge detection and hold-to-auto-repeat FSM; emits single-cycle step pulses, combinational
// from the current button levels (zero added latency). No backpressure: steps are fire-and-forget.
module preset_button_repeater
    import thresh_presets_pkg::*;
#(
    parameter int PARM_HOLD_CYCLES   = 20_000_000,
    parameter int PARM_REPEAT_CYCLES = 4_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_next,
    input  logic i_btn_prev,
    output logic o_step_next,
    output logic o_step_prev
);
    localparam int MAXC = (PARM_HOLD_CYCLES > PARM_REPEAT_CYCLES) ? PARM_HOLD_CYCLES : PARM_REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [1:0]    P_IDLE      = ST_IDLE;
    localparam logic [1:0]    P_HOLD_WAIT = ST_HOLD_WAIT;
    localparam logic [1:0]    P_REPEAT    = ST_REPEAT;
    localparam logic [CW-1:0] L_HOLD_LAST = CW'(PARM_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] L_RPT_LAST  = CW'(PARM_REPEAT_CYCLES - 1);

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_dir, w_dir_nxt;
    logic          r_prev_next, r_prev_prev;
    logic          r_armed;
    logic          w_step, w_both, w_rise_next, w_rise_prev, w_held;

    assign w_both      = i_btn_next & i_btn_prev;
    assign w_rise_next = i_btn_next & ~r_prev_next;
    assign w_rise_prev = i_btn_prev & ~r_prev_prev;
    assign w_held      = r_dir ? i_btn_next : i_btn_prev;
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // r_armed masks the first cycle after reset so a button held through reset never steps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        if (!r_armed) begin
            w_state_nxt = P_IDLE;
        end else if (w_both) begin
            w_state_nxt = P_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                P_IDLE: begin
                    if (w_rise_next || w_rise_prev) begin
                        w_step      = 1'b1;
                        w_dir_nxt   = w_rise_next;
                        w_state_nxt = P_HOLD_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                P_HOLD_WAIT, P_REPEAT: begin
                    if (!w_held) begin
                        w_state_nxt = P_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == ((r_state == P_HOLD_WAIT) ? L_HOLD_LAST : L_RPT_LAST)) begin
                        w_step      = 1'b1;
                        w_state_nxt = P_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = P_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= P_IDLE;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_prev_next <= 1'b0;
            r_prev_prev <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir_nxt;
            r_prev_next <= i_btn_next;
            r_prev_prev <= i_btn_prev;
            r_armed     <= 1'b1;
        end
    end

    assign o_step_next = w_step &  w_dir_nxt;
    assign o_step_prev = w_step & ~w_dir_nxt;

endmodule

// File: rtl/thresh_presets_stepper.sv
// Preset selector: button steps (with auto-repeat) or direct host load pick a threshold/timer pair.
// One-cycle registered latency; no backpressure, rejected loads pulse o_sel_error.
module thresh_presets_stepper
    import thresh_presets_pkg::*;
#(
    parameter int PARM_NUM_PRESETS  = 16,
    parameter int PARM_ACTIVE_COUNT = 10,
    parameter int PARM_DATA_WIDTH   = 16,
    parameter logic [PARM_NUM_PRESETS*PARM_DATA_WIDTH-1:0] parm_presets_config_thresholds =
        {PARM_NUM_PRESETS{PARM_DATA_WIDTH'(65000)}},
    parameter logic [PARM_NUM_PRESETS*PARM_DATA_WIDTH-1:0] parm_presets_config_timers =
        {PARM_NUM_PRESETS{PARM_DATA_WIDTH'(65000)}},
    parameter int PARM_HOLD_CYCLES   = 20_000_000,
    parameter int PARM_REPEAT_CYCLES = 4_000_000
) (
    input  logic                      i_clk_20mhz,
    input  logic                      i_rst_20mhz,
    thresh_presets_stepper_if.slave   bus
);
    localparam int IW = $clog2(PARM_NUM_PRESETS);
    localparam int W  = PARM_DATA_WIDTH;

    localparam logic [PKG_IDX_W-1:0] L_COUNT   = PKG_IDX_W'(PARM_ACTIVE_COUNT);
    localparam logic [W-1:0]         L_THRESH0 = W'(f_preset_slice(PKG_TBL_W'(parm_presets_config_thresholds),
                                                                   PARM_NUM_PRESETS, W, 0));
    localparam logic [W-1:0]         L_TIMER0  = W'(f_preset_slice(PKG_TBL_W'(parm_presets_config_timers),
                                                                   PARM_NUM_PRESETS, W, 0));

    logic [W-1:0]  w_thresh_tbl [PARM_NUM_PRESETS];
    logic [W-1:0]  w_timer_tbl  [PARM_NUM_PRESETS];
    logic          w_step_next, w_step_prev;
    logic          w_load, w_reject;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_thresh, r_timer;
    logic          r_changed, r_sel_error;

    for (genvar k = 0; k < PARM_NUM_PRESETS; k++) begin : g_tbl
        assign w_thresh_tbl[k] = W'(f_preset_slice(PKG_TBL_W'(parm_presets_config_thresholds),
                                                   PARM_NUM_PRESETS, W, k));
        assign w_timer_tbl[k]  = W'(f_preset_slice(PKG_TBL_W'(parm_presets_config_timers),
                                                   PARM_NUM_PRESETS, W, k));
    end

    preset_button_repeater #(
        .PARM_HOLD_CYCLES   (PARM_HOLD_CYCLES),
        .PARM_REPEAT_CYCLES (PARM_REPEAT_CYCLES)
    ) u_repeater (
        .i_clk       (i_clk_20mhz),
        .i_rst       (i_rst_20mhz),
        .i_btn_next  (bus.i_btn_next),
        .i_btn_prev  (bus.i_btn_prev),
        .o_step_next (w_step_next),
        .o_step_prev (w_step_prev)
    );

    // A direct load wins outright; a coincident button step is simply discarded.
    always_comb begin
        w_idx_nxt = r_idx;
        w_load    = 1'b0;
        w_reject  = 1'b0;
        if (bus.i_sel_valid) begin
            if (PKG_IDX_W'(bus.i_sel_index) < L_COUNT) begin
                w_idx_nxt = bus.i_sel_index;
                w_load    = 1'b1;
            end else begin
                w_reject  = 1'b1;
            end
        end else if (PARM_ACTIVE_COUNT > 1) begin
            if (w_step_next) begin
                w_idx_nxt = IW'(f_wrap_inc(PKG_IDX_W'(r_idx), L_COUNT));
                w_load    = 1'b1;
            end else if (w_step_prev) begin
                w_idx_nxt = IW'(f_wrap_dec(PKG_IDX_W'(r_idx), L_COUNT));
                w_load    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            r_idx       <= '0;
            r_thresh    <= L_THRESH0;
            r_timer     <= L_TIMER0;
            r_changed   <= 1'b0;
            r_sel_error <= 1'b0;
        end else begin
            r_changed   <= w_load;
            r_sel_error <= w_reject;
            if (w_load) begin
                r_idx    <= w_idx_nxt;
                r_thresh <= w_thresh_tbl[w_idx_nxt];
                r_timer  <= w_timer_tbl[w_idx_nxt];
            end
        end
    end

    assign bus.o_value_enum    = r_idx;
    assign bus.o_value_thresh  = r_thresh;
    assign bus.o_value_timer   = r_timer;
    assign bus.o_value_changed = r_changed;
    assign bus.o_sel_error     = r_sel_error;

endmodule

// File: tb/tb_thresh_presets_stepper.sv
// Directed bench for thresh_presets_stepper with short hold/repeat periods and hand-computed expectations.
module tb_thresh_presets_stepper;

    localparam logic [255:0] L_THR = {16'd100, 16'd200, 16'd300, 16'd400, 16'd500,
                                      16'd600, 16'd700, 16'd800, 16'd900, 16'd1000,
                                      {6{16'd65000}}};
    localparam logic [255:0] L_TMR = {16'd5000, 16'd5001, 16'd5002, 16'd5003, 16'd5004,
                                      16'd5005, 16'd5006, 16'd5007, 16'd5008, 16'd5009,
                                      {6{16'd65000}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_chg = 0;
    int   base;

    thresh_presets_stepper_if #(.IW(4), .W(16)) bus ();

    thresh_presets_stepper #(
        .PARM_NUM_PRESETS               (16),
        .PARM_ACTIVE_COUNT              (10),
        .PARM_DATA_WIDTH                (16),
        .parm_presets_config_thresholds (L_THR),
        .parm_presets_config_timers     (L_TMR),
        .PARM_HOLD_CYCLES               (8),
        .PARM_REPEAT_CYCLES             (3)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_value_changed === 1'b1) n_chg++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic sel(input logic [3:0] idx);
        bus.i_sel_valid = 1'b1;
        bus.i_sel_index = idx;
        tick(1);
        bus.i_sel_valid = 1'b0;
    endtask

    initial begin
        bus.i_btn_next  = 1'b0;
        bus.i_btn_prev  = 1'b0;
        bus.i_sel_valid = 1'b0;
        bus.i_sel_index = '0;
        tick(2);
        chk("rst_enum",    bus.o_value_enum,    0);
        chk("rst_thresh",  bus.o_value_thresh,  100);
        chk("rst_timer",   bus.o_value_timer,   5000);
        chk("rst_changed", bus.o_value_changed, 0);
        chk("rst_err",     bus.o_sel_error,     0);

        // button held across reset release must not step
        bus.i_btn_next = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("held_rst_enum", bus.o_value_enum, 0);
        chk("held_rst_chg",  n_chg, 0);
        bus.i_btn_next = 1'b0;
        tick(1);

        base = n_chg;
        for (int i = 1; i <= 10; i++) begin
            bus.i_btn_next = 1'b1;
            tick(1);
            chk("next_chg",    bus.o_value_changed, 1);
            chk("next_enum",   bus.o_value_enum,    i % 10);
            chk("next_thresh", bus.o_value_thresh,  100 * ((i % 10) + 1));
            bus.i_btn_next = 1'b0;
            tick(1);
            chk("next_chg_low", bus.o_value_changed, 0);
        end
        chk("next_pulses", n_chg - base, 10);

        base = n_chg;
        bus.i_btn_prev = 1'b1;
        tick(1);
        chk("prev_wrap_enum",   bus.o_value_enum,    9);
        chk("prev_wrap_thresh", bus.o_value_thresh,  1000);
        chk("prev_wrap_timer",  bus.o_value_timer,   5009);
        bus.i_btn_prev = 1'b0;
        tick(1);
        chk("prev_pulses", n_chg - base, 1);

        sel(4'd0);
        chk("sel0_enum", bus.o_value_enum, 0);
        chk("sel0_chg",  bus.o_value_changed, 1);
        tick(1);

        bus.i_btn_next = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("rpt_cadence", bus.o_value_changed,
                (c == 0 || c == 8 || c == 11 || c == 14 || c == 17) ? 1 : 0);
        end
        bus.i_btn_next = 1'b0;
        tick(1);
        chk("rpt_enum",  bus.o_value_enum,  5);
        chk("rpt_timer", bus.o_value_timer, 5005);

        sel(4'd5);
        chk("sel_same_chg",  bus.o_value_changed, 1);
        chk("sel_same_enum", bus.o_value_enum,    5);
        sel(4'd12);
        chk("sel12_err",  bus.o_sel_error,     1);
        chk("sel12_enum", bus.o_value_enum,    5);
        chk("sel12_chg",  bus.o_value_changed, 0);
        sel(4'd10);
        chk("sel10_err", bus.o_sel_error, 1);
        sel(4'd9);
        chk("sel9_err",    bus.o_sel_error,    0);
        chk("sel9_thresh", bus.o_value_thresh, 1000);

        sel(4'd2);
        chk("sel2_enum", bus.o_value_enum, 2);
        tick(1);
        bus.i_btn_next  = 1'b1;
        bus.i_sel_valid = 1'b1;
        bus.i_sel_index = 4'd7;
        tick(1);
        bus.i_sel_valid = 1'b0;
        chk("prio_enum",   bus.o_value_enum,    7);
        chk("prio_thresh", bus.o_value_thresh,  800);
        chk("prio_chg",    bus.o_value_changed, 1);
        bus.i_btn_next = 1'b0;
        tick(1);
        chk("prio_enum_after", bus.o_value_enum,    7);
        chk("prio_chg_after",  bus.o_value_changed, 0);

        base = n_chg;
        bus.i_btn_next = 1'b1;
        bus.i_btn_prev = 1'b1;
        tick(12);
        chk("both_enum",   bus.o_value_enum, 7);
        chk("both_pulses", n_chg - base, 0);
        bus.i_btn_next = 1'b0;
        bus.i_btn_prev = 1'b0;
        tick(1);
        bus.i_btn_next = 1'b1;
        tick(1);
        chk("fresh_enum", bus.o_value_enum,    8);
        chk("fresh_chg",  bus.o_value_changed, 1);
        bus.i_btn_next = 1'b0;
        tick(1);

        sel(4'd0);
        tick(1);
        bus.i_btn_next = 1'b1;
        tick(12);
        chk("midrpt_enum", bus.o_value_enum, 3);
        rst = 1'b1;
        #1;
        chk("arst_enum",   bus.o_value_enum,    0);
        chk("arst_thresh", bus.o_value_thresh,  100);
        chk("arst_timer",  bus.o_value_timer,   5000);
        chk("arst_chg",    bus.o_value_changed, 0);
        base = n_chg;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("post_rst_enum",   bus.o_value_enum, 0);
        chk("post_rst_pulses", n_chg - base, 0);
        bus.i_btn_next = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/thresh_presets_stepper.md
# thresh_presets_stepper

Parametrised preset selector that steps through a table of threshold/timer preset pairs, indexed MSB-first. Stepping forward and backward is driven by debounced buttons, with hold-to-auto-repeat. A direct indexed load port lets a host (UART command parser) jump to any active preset. It sits between the debounced button/command logic and the ACL threshold/activity-timer configuration path, and replaces the fixed forward-only 0..9 selector.

## Interface
- PARM_NUM_PRESETS, 16: entries in each preset table (≥2).
- PARM_ACTIVE_COUNT, 10: entries reachable, indices 0..PARM_ACTIVE_COUNT-1. Range 1..PARM_NUM_PRESETS.
- PARM_DATA_WIDTH, 16: width of each threshold and timer entry.
- parm_presets_config_thresholds, all 16'd65000: flat vector PARM_NUM_PRESETS*PARM_DATA_WIDTH. Entry k is at [(PARM_NUM_PRESETS-k)*W-1 -: W].
- parm_presets_config_timers, all 16'd65000: same layout as thresholds.
- PARM_HOLD_CYCLES, 20_000_000: cycles a button must be held after its first step before auto-repeat begins (1 s at 20 MHz).
- PARM_REPEAT_CYCLES, 4_000_000: cycles between auto-repeat steps (200 ms).
- Ports (IW = $clog2(PARM_NUM_PRESETS)):
- i_clk_20mhz  in  1  sole clock.
- i_rst_20mhz  in  1  reset; asynchronous, active-high.
- i_btn_next  in  1  debounced level; step +1.
- i_btn_prev  in  1  debounced level; step −1.
- i_sel_valid  in  1  single-cycle strobe requesting a direct load.
- i_sel_index  in  IW  preset index for the direct load.
- o_value_enum  out  IW  current index, registered.
- o_value_thresh  out  W  threshold of current index, registered.
- o_value_timer  out  W  timer of current index, registered.
- o_value_changed  out  1  one-cycle pulse, coincident with new output values.
- o_sel_error  out  1  one-cycle pulse when a direct load is rejected.

## Operation
- Edge detection: the previous level of each button is registered. A rising edge is level=1 while the registered previous level is 0.
- Button FSM states:
  - ST_IDLE: a single-button rising edge issues one step and moves to ST_HOLD_WAIT; the hold counter clears.
  - ST_HOLD_WAIT: counts while the same button stays high. At PARM_HOLD_CYCLES-1 it issues a step, moves to ST_REPEAT and clears the counter.
  - ST_REPEAT: issues a step every PARM_REPEAT_CYCLES.
  - ST_HOLD_WAIT and ST_REPEAT return to ST_IDLE with no step when the held button falls or the other button rises.
- Both buttons high in the same cycle: no step, and the FSM goes to ST_IDLE. A new step needs a fresh single-button rising edge.
- Wrap: next from PARM_ACTIVE_COUNT-1 goes to 0; prev from 0 goes to PARM_ACTIVE_COUNT-1. With PARM_ACTIVE_COUNT=1 every step is a no-op and does not pulse o_value_changed.
- Direct load:
  - Accepted when i_sel_index < PARM_ACTIVE_COUNT.
  - Rejected otherwise: o_sel_error pulses and the index is unchanged.
  - Priority over any button step in the same cycle; that button step is dropped. The button FSM still updates state normally.
  - Loading the current index is accepted and pulses o_value_changed.
- Threshold and timer outputs are the table entries at the new index, registered together with o_value_enum.

## Timing
- Reset values: o_value_enum=0; o_value_thresh and o_value_timer = entry 0; o_value_changed=0; o_sel_error=0; FSM=ST_IDLE; counters=0; previous-button registers=0. A button held through reset deassertion does not step.
- Latency: one cycle. A button edge or i_sel_valid seen at clock edge n updates the outputs at edge n+1. o_value_changed and o_sel_error are high for exactly that one cycle.
- Auto-repeat: the first repeat step lands PARM_HOLD_CYCLES cycles after the initial step; each later step lands PARM_REPEAT_CYCLES cycles after the previous one.
- Reset mid-hold clears the FSM and counters immediately (asynchronous); outputs return to entry 0.
- Hold counter width: $clog2(max(PARM_HOLD_CYCLES, PARM_REPEAT_CYCLES)+1). The counter saturates and never wraps.

## Structure
- Package thresh_presets_pkg holds:
  - t_btn_rpt_state enum (ST_IDLE, ST_HOLD_WAIT, ST_REPEAT).
  - Functions f_preset_slice(table, k) and f_wrap_inc/f_wrap_dec(idx, count).
- Sub-module preset_button_repeater holds edge detection, the FSM and the hold counter. It outputs single-cycle o_step_next and o_step_prev pulses. The top level holds the index register, direct-load arbitration and output registers.

## Test plan
- Reset, then 10 next-edges (HOLD large), entries 0..9 of 16'd100..16'd1000 → enum 1,2,…,9,0; thresh tracks the entry; 10 changed pulses.
- prev edge at index 0, ACTIVE_COUNT=10 → enum=9 one cycle later; changed pulses once.
- HOLD=8, REPEAT=3, hold next 20 cycles from index 0 → steps at cycles 0, 8, 11, 14, 17; enum=5.
- i_sel_valid with index 12 (ACTIVE_COUNT=10) → o_sel_error pulse, enum unchanged. Index 7 coincident with a next-edge at enum 2 → enum=7; step dropped.
- Both buttons rise together → no change, FSM returns to idle. Reset asserted mid-repeat → enum=0 immediately, entry-0 values, no pulses.
